mem_access_unit: RTL and testbench

//  MEM-stage load/store sequencer between the pipeline's EX/MEM register and the word-wide data memory.

---
 rtl/mem_access_unit.sv | 208 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   MEM-stage load/store sequencer sitting between the EX/MEM register and a
//   word-wide data memory with a registered read port. Byte and halfword loads
//   are extracted from the read word and sign- or zero-extended. Byte and
//   halfword stores are done as read-modify-write on the containing word.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_op                MIPS opcode (LB/LH/LW/LBU/LHU/SB/SH/SW)
//   req_addr              byte address
//   req_wdata             store data (SB: [7:0], SH: [15:0], SW: all)
//   load_data/load_valid  extended load result and its one-cycle strobe
//   store_done            one-cycle strobe once the store has been written
//   err                   one-cycle strobe for a rejected request
//   mem_address           registered word address to the data memory
//   mem_in_data           registered write data to the data memory
//   mem_write             registered write enable to the data memory
//   mem_out_data          read word, valid the cycle after a non-write edge
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_W     = 11,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              store_done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_in_data,
    output logic              mem_write,
    input  logic [31:0]       mem_out_data
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_RSP, S_WR} state_t;

    state_t      state_reg, state_next;
    logic [5:0]  op_reg;
    logic [1:0]  off_reg;
    logic [15:0] wdata_reg;    // only SB/SH need the latched data

    logic        accept;
    logic        req_err;
    logic        op_known, op_half, op_word;
    logic        op_reg_is_load;
    logic [4:0]  byte_sh, half_sh;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // ---------------------------------------------------------------- decode
    always_comb begin
        op_known = 1'b0;
        op_half  = 1'b0;
        op_word  = 1'b0;
        case (req_op)
            OP_LB, OP_LBU, OP_SB: op_known = 1'b1;
            OP_LH, OP_LHU, OP_SH: begin op_known = 1'b1; op_half = 1'b1; end
            OP_LW, OP_SW:         begin op_known = 1'b1; op_word = 1'b1; end
            default:              op_known = 1'b0;
        endcase
    end

    // Any address bit above the memory's reach makes the request invalid.
    always_comb begin
        req_err = !op_known
               || ((req_addr >> (ADDR_W + 2)) != 32'd0)
               || (op_half && req_addr[0])
               || (op_word && (req_addr[1:0] != 2'b00));
    end

    assign accept         = req_valid && req_ready;
    assign op_reg_is_load = !op_reg[3];   // loads are 100xxx, stores 101xxx

    // ---------------------------------------------------- lane extraction
    // Big-endian puts byte offset 0 in the top lane, so the shift is
    // (3-off)*8 for bytes and (2-off)*8 for halves; little-endian is off*8.
    always_comb begin
        if (BIG_ENDIAN) begin
            byte_sh = {~off_reg, 3'b000};
            half_sh = {~off_reg[1], 4'b0000};
        end else begin
            byte_sh = {off_reg, 3'b000};
            half_sh = {off_reg[1], 4'b0000};
        end
    end

    assign byte_val = mem_out_data[byte_sh +: 8];
    assign half_val = mem_out_data[half_sh +: 16];

    always_comb begin
        load_ext = mem_out_data;
        case (op_reg)
            OP_LB:   load_ext = {{24{byte_val[7]}}, byte_val};
            OP_LBU:  load_ext = {24'd0, byte_val};
            OP_LH:   load_ext = {{16{half_val[15]}}, half_val};
            OP_LHU:  load_ext = {16'd0, half_val};
            default: load_ext = mem_out_data;
        endcase
    end

    // Replace only the addressed lane(s) of the old word.
    always_comb begin
        if (op_reg == OP_SH)
            merged = (mem_out_data & ~(32'h0000_FFFF << half_sh))
                   | ({16'd0, wdata_reg} << half_sh);
        else
            merged = (mem_out_data & ~(32'h0000_00FF << byte_sh))
                   | ({24'd0, wdata_reg[7:0]} << byte_sh);
    end

    // ------------------------------------------------------ state register
    always_ff @(posedge clock) begin
        if (reset)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    // ------------------------------------------------------ next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept && !req_err)
                        state_next = (req_op == OP_SW) ? S_WR : S_RD;
            S_RD:   state_next = S_RSP;
            S_RSP:  state_next = op_reg_is_load ? S_IDLE : S_WR;
            S_WR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------ outputs
    always_comb begin
        req_ready = (state_reg == S_IDLE);
    end

    // Registered datapath and strobes; the strobes default low every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_reg      <= 6'd0;
            off_reg     <= 2'd0;
            wdata_reg   <= 16'd0;
            mem_address <= '0;
            mem_in_data <= 32'd0;
            mem_write   <= 1'b0;
            load_data   <= 32'd0;
            load_valid  <= 1'b0;
            store_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            store_done <= 1'b0;
            err        <= 1'b0;
            case (state_reg)
                S_IDLE: if (accept) begin
                    if (req_err) begin
                        err <= 1'b1;
                    end else begin
                        op_reg      <= req_op;
                        off_reg     <= req_addr[1:0];
                        wdata_reg   <= req_wdata[15:0];
                        mem_address <= req_addr[ADDR_W+1:2];
                        if (req_op == OP_SW) begin
                            mem_in_data <= req_wdata;
                            mem_write   <= 1'b1;
                        end else begin
                            mem_write   <= 1'b0;
                        end
                    end
                end
                S_RSP: begin
                    if (op_reg_is_load) begin
                        load_data  <= load_ext;
                        load_valid <= 1'b1;
                    end else begin
                        mem_in_data <= merged;
                        mem_write   <= 1'b1;
                    end
                end
                S_WR: begin
                    mem_write  <= 1'b0;
                    store_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] load_data;
    logic        load_valid;
    logic        store_done;
    logic        err;
    logic [10:0] mem_address;
    logic [31:0] mem_in_data;
    logic        mem_write;
    logic [31:0] mem_out_data;

    // data memory model with a preload port
    logic [31:0] dmem [0:2047];
    logic        pl_en;
    logic [10:0] pl_addr;
    logic [31:0] pl_data;

    int vec  = 0;
    int errs = 0;
    int lat;
    int wr_cnt;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_write) begin
            dmem[mem_address] <= mem_in_data;
        end else begin
            if (pl_en) dmem[pl_addr] <= pl_data;
            mem_out_data <= dmem[mem_address];
        end
    end

    mem_access_unit #(.ADDR_W(11), .BIG_ENDIAN(1'b1)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .store_done   (store_done),
        .err          (err),
        .mem_address  (mem_address),
        .mem_in_data  (mem_in_data),
        .mem_write    (mem_write),
        .mem_out_data (mem_out_data)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vec++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Issue one request, then wait (bounded) for its pulse. lat counts edges
    // from the accept edge to the pulse cycle; wr_cnt counts mem_write cycles.
    task automatic do_req(input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, output int l, output int w);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
        l = 1;
        w = mem_write ? 1 : 0;
        while (!(load_valid || store_done || err) && l < 20) begin
            tick();
            l++;
            if (mem_write) w++;
        end
        $display("req op=%b addr=%h wdata=%h -> lat=%0d load_data=%h lv=%b sd=%b err=%b wr=%0d",
                 op, addr, wd, l, load_data, load_valid, store_done, err, w);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = 6'd0; req_addr = 32'd0; req_wdata = 32'd0;
        pl_en = 1'b0; pl_addr = 11'd0; pl_data = 32'd0;
        tick();
        pl_en = 1'b1; pl_addr = 11'd5; pl_data = 32'h8899AABB; tick();
        pl_addr = 11'd4; pl_data = 32'h11223344; tick();
        pl_en = 1'b0; tick();

        check("rst_ready",   {31'd0, req_ready},  32'd1);
        check("rst_ldata",   load_data,           32'd0);
        check("rst_maddr",   {21'd0, mem_address}, 32'd0);
        check("rst_mindata", mem_in_data,         32'd0);
        check("rst_mwrite",  {31'd0, mem_write},  32'd0);
        check("rst_pulses",  {29'd0, load_valid, store_done, err}, 32'd0);
        reset = 1'b0;
        tick();

        // LB sign-extend, latency 3, single-cycle strobe
        do_req(OP_LB, 32'h15, 32'd0, lat, wr_cnt);
        check("lb_lat",   lat, 3);
        check("lb_valid", {31'd0, load_valid}, 32'd1);
        check("lb_data",  load_data, 32'hFFFFFF99);
        check("lb_nowr",  wr_cnt, 0);
        tick();
        check("lb_pulse1", {31'd0, load_valid}, 32'd0);

        do_req(OP_LHU, 32'h16, 32'd0, lat, wr_cnt);
        check("lhu_data", load_data, 32'h0000AABB);
        do_req(OP_LH, 32'h14, 32'd0, lat, wr_cnt);
        check("lh_data", load_data, 32'hFFFF8899);
        do_req(OP_LW, 32'h14, 32'd0, lat, wr_cnt);
        check("lw_data", load_data, 32'h8899AABB);
        do_req(OP_LBU, 32'h14, 32'd0, lat, wr_cnt);
        check("lbu_data", load_data, 32'h00000088);

        // SB read-modify-write
        do_req(OP_SB, 32'h17, 32'h12345666, lat, wr_cnt);
        check("sb_lat",  lat, 4);
        check("sb_done", {31'd0, store_done}, 32'd1);
        check("sb_wr1",  wr_cnt, 1);
        check("sb_mem",  dmem[5], 32'h8899AA66);
        tick();
        check("sb_pulse1", {31'd0, store_done}, 32'd0);

        do_req(OP_SH, 32'h16, 32'hCAFE1234, lat, wr_cnt);
        check("sh_lat", lat, 4);
        check("sh_mem", dmem[5], 32'h88991234);

        // SW then LW accepted on the store_done cycle
        do_req(OP_SW, 32'h20, 32'hDEADBEEF, lat, wr_cnt);
        check("sw_lat",   lat, 2);
        check("sw_done",  {31'd0, store_done}, 32'd1);
        check("sw_wr1",   wr_cnt, 1);
        check("sw_ready", {31'd0, req_ready}, 32'd1);
        check("sw_mem",   dmem[8], 32'hDEADBEEF);
        do_req(OP_LW, 32'h20, 32'd0, lat, wr_cnt);
        check("b2b_lat",  lat, 3);
        check("b2b_data", load_data, 32'hDEADBEEF);

        // rejected requests
        do_req(OP_LW, 32'h22, 32'd0, lat, wr_cnt);
        check("e_lw_lat", lat, 1);
        check("e_lw_err", {31'd0, err}, 32'd1);
        check("e_lw_nowr", wr_cnt, 0);
        check("e_lw_ready", {31'd0, req_ready}, 32'd1);
        tick();
        check("e_lw_pulse1", {31'd0, err}, 32'd0);
        do_req(OP_SH, 32'h01, 32'hFFFF, lat, wr_cnt);
        check("e_sh_err", {31'd0, err}, 32'd1);
        check("e_sh_nowr", wr_cnt, 0);
        do_req(6'b000000, 32'h10, 32'd0, lat, wr_cnt);
        check("e_op_err", {31'd0, err}, 32'd1);
        check("e_op_nowr", wr_cnt, 0);
        do_req(OP_LW, 32'h2000, 32'd0, lat, wr_cnt);
        check("e_rng_err", {31'd0, err}, 32'd1);
        check("e_rng_lat", lat, 1);
        check("e_maddr_held", {21'd0, mem_address}, 32'h8);
        tick();
        check("e_ready_after", {31'd0, req_ready}, 32'd1);
        check("e_mem4", dmem[4], 32'h11223344);

        // reset during RSP of SH aborts the store
        req_valid = 1'b1; req_op = OP_SH; req_addr = 32'h10; req_wdata = 32'h5555;
        tick();
        req_valid = 1'b0;
        check("ab_busy", {31'd0, req_ready}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ab_ready",   {31'd0, req_ready}, 32'd1);
        check("ab_mindata", mem_in_data, 32'd0);
        check("ab_ldata",   load_data, 32'd0);
        check("ab_maddr",   {21'd0, mem_address}, 32'd0);
        check("ab_pulses",  {28'd0, mem_write, load_valid, store_done, err}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ab_quiet", {30'd0, mem_write, store_done}, 32'd0);
        end
        check("ab_mem4", dmem[4], 32'h11223344);
        $display("abort test: word4=%h ready=%b", dmem[4], req_ready);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
